// File: rtl/serv_ava.sv
// serv_ava: multi-cycle AVA responder for avg/avgr/absd/minu/maxu and iterative cpop/clz/ctz.
// Define SERV_AVA_EARLY_EXIT_EN to let the count ops leave BUSY as soon as the result is settled.
module serv_ava #(
  parameter int STEP           = 4,
  parameter     RESET_STRATEGY = "MINI"
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ava_valid,
  input  logic [2:0]  i_ava_funct3,
  input  logic [31:0] i_ava_rs1,
  input  logic [31:0] i_ava_rs2,
  output logic [31:0] o_ava_rd,
  output logic        o_ava_ready
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;
  localparam logic [5:0] LAST  = 6'(32 / STEP - 1);
  localparam bit         RST_DP = RESET_STRATEGY != "NONE";
  logic [1:0]  r_state;
  logic [2:0]  r_funct3;
  logic [31:0] r_a, r_b, r_rd;
  logic [5:0]  r_cnt, r_acc;
  logic        r_found;
  logic        w_cpop, w_clz, w_count, w_last, w_early, w_exit, w_found;
  logic [5:0]  w_acc;
  logic [31:0] w_src, w_a_nxt, w_absd, w_arith;
  logic [32:0] w_sum;
  assign w_cpop  = r_funct3 == 3'b101;
  assign w_clz   = r_funct3 == 3'b110;
  assign w_count = r_funct3[2] & |r_funct3[1:0];
  assign w_sum   = {1'b0, r_a} + {1'b0, r_b} + {32'd0, r_funct3[0]};
  assign w_absd  = r_a >= r_b ? r_a - r_b : r_b - r_a;
  assign w_arith = !r_funct3[2] && !r_funct3[1] ? w_sum[32:1] :
                   r_funct3 == 3'b010 ? w_absd :
                   r_funct3 == 3'b011 ? (r_a < r_b ? r_a : r_b) :
                   (r_a < r_b ? r_b : r_a);
  // clz walks MSB first: bit-reverse so the low STEP bits are always the next group
  assign w_src   = w_clz ? {<<{r_a}} : r_a;
  assign w_a_nxt = w_clz ? r_a << STEP : r_a >> STEP;
  always_comb begin
    w_acc   = r_acc;
    w_found = r_found;
    for (int i = 0; i < STEP; i++) begin
      w_acc   = w_acc + {5'd0, w_cpop ? w_src[i] : !w_found && !w_src[i]};
      w_found = w_found | w_src[i];
    end
  end
  assign w_last = r_cnt == LAST;
`ifdef SERV_AVA_EARLY_EXIT_EN
  assign w_early = w_cpop ? w_a_nxt == '0 : w_found;
`else
  assign w_early = 1'b0;
`endif
  assign w_exit = !w_count | w_last | w_early;
  always_ff @(posedge i_clk)
    if (i_rst) r_state <= IDLE;
    else r_state <= r_state == IDLE ? (i_ava_valid ? BUSY : IDLE) :
                    r_state == BUSY ? (w_exit ? DONE : BUSY) :
                    r_state == DONE ? DRAIN :
                    (i_ava_valid ? DRAIN : IDLE);
  always_ff @(posedge i_clk)
    if (i_rst) begin
      if (RST_DP) begin
        r_funct3 <= '0;
        r_a      <= '0;
        r_b      <= '0;
        r_cnt    <= '0;
        r_acc    <= '0;
        r_found  <= 1'b0;
        r_rd     <= '0;
      end
    end else if (r_state == IDLE && i_ava_valid) begin
      r_funct3 <= i_ava_funct3;
      r_a      <= i_ava_rs1;
      r_b      <= i_ava_rs2;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_found  <= 1'b0;
    end else if (r_state == BUSY) begin
      r_a     <= w_a_nxt;
      r_cnt   <= r_cnt + 6'd1;
      r_acc   <= w_acc;
      r_found <= w_found;
      if (w_exit) r_rd <= w_count ? {26'd0, w_acc} : w_arith;
    end
  assign o_ava_ready = r_state == DONE;
  assign o_ava_rd    = r_rd;
endmodule
